nibble_add_sched: RTL and testbench

//  Time-shares one 4-bit carry-select adder slice (adder_cs) between two IF-stage requesters.

---
 rtl/nibble_add_sched_pkg.sv | 21 ++
 rtl/nibble_add_sched_adder_cs.sv | 20 ++
 rtl/nibble_add_sched.sv | 131 +++++++++++++
 tb/tb_nibble_add_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_sched_pkg.sv
// Shared types and constants for the nibble-serial add scheduler.
// Holds the FSM state encoding, requester ids and the round-robin pick helper.
package nibble_add_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic ID_PC = 1'b0;
  localparam logic ID_BR = 1'b1;

  localparam int unsigned NIB_BITS = 4;

  // The pointer's requester wins if valid, otherwise the other one.
  function automatic logic rr_pick(input logic [1:0] valid, input logic ptr);
    return valid[ptr] ? ptr : ~ptr;
  endfunction

endpackage

// File: rtl/nibble_add_sched_adder_cs.sv
// 4-bit carry-select adder slice: both carry-in cases are formed up front
// and the incoming carry selects the result.
module adder_cs (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] sum_c0;
  logic [4:0] sum_c1;

  always_comb begin
    sum_c0  = {1'b0, a} + {1'b0, b};
    sum_c1  = {1'b0, a} + {1'b0, b} + 5'd1;
    {co, s} = ci ? sum_c1 : sum_c0;
  end

endmodule

// File: rtl/nibble_add_sched.sv
// Shares one 4-bit adder slice between the PC incrementer (id 0) and the
// branch-target adder (id 1); each add runs LSB-first, one nibble per cycle.
module nibble_add_sched
  import nibble_add_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req_ci,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_co,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned NUM_NIB = WIDTH / NIB_BITS;
  localparam int unsigned NIB_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [NIB_W-1:0]   nib_idx_q, nib_idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               id_q, id_d;
  logic               co_q, co_d;

  logic               grant;
  logic [NIB_W+1:0]   nib_lo;
  logic [3:0]         nib_a, nib_b, nib_s;
  logic               nib_co;

  assign nib_lo = {nib_idx_q, 2'b00};
  assign nib_a  = a_q[nib_lo +: NIB_BITS];
  assign nib_b  = b_q[nib_lo +: NIB_BITS];

  adder_cs u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    nib_idx_d = nib_idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    id_d      = id_q;
    co_d      = co_q;
    req_ready = '0;
    grant     = rr_pick(req_valid, rr_ptr_q);

    unique case (state_q)
      S_IDLE: begin
        // Ready is gated by rst_n so every output reads zero while reset is held.
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready[grant] = 1'b1;
          a_d       = (grant == ID_PC) ? req0_a : req1_a;
          b_d       = (grant == ID_PC) ? req0_b : req1_b;
          carry_d   = req_ci[grant];
          id_d      = grant;
          nib_idx_d = '0;
          rr_ptr_d  = ~grant;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[nib_lo +: NIB_BITS] = nib_s;
        carry_d   = nib_co;
        nib_idx_d = nib_idx_q + 1'b1;
        if (nib_idx_q == NIB_W'(NUM_NIB - 1)) begin
          co_d      = nib_co;
          nib_idx_d = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= ID_PC;
      nib_idx_q <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      id_q      <= ID_PC;
      co_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      nib_idx_q <= nib_idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      id_q      <= id_d;
      co_q      <= co_d;
    end
  end

  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_sum   = sum_q;
  assign res_co    = co_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Scoreboard bench for nibble_add_sched: the driver queues hand-computed
// results on each accept, and a negedge monitor checks them as they retire.
module tb_nibble_add_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req_ci;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_co;
  logic        res_id;
  logic        busy;

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        id;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        exp_rr;

  nibble_add_sched #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req_ci    (req_ci),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_co    (res_co),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: retires results on the handshake and polices req_ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready) begin
      check("result_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("res_sum", res_sum, e.sum);
        check("res_co", 32'(res_co), 32'(e.co));
        check("res_id", 32'(res_id), 32'(e.id));
      end
    end
    if (req_ready != 2'b00) begin
      check("req_ready_onehot", 32'(req_ready == 2'b11), 32'd0);
      check("req_ready_only_idle", 32'(busy), 32'd0);
    end
  end

  task automatic load(input logic id, input logic [31:0] a, input logic [31:0] b, input logic ci);
    if (id) begin
      req1_a = a;
      req1_b = b;
    end else begin
      req0_a = a;
      req0_b = b;
    end
    req_ci[id] = ci;
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic [31:0] esum, input logic eco, input bit chk_lat);
    bit          got;
    int unsigned k;
    @(posedge clk);
    #1;
    load(id, a, b, ci);
    req_valid     = 2'b00;
    req_valid[id] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        check("grant", 32'(req_ready), id ? 32'd2 : 32'd1);
        got = 1'b1;
      end
    end
    if (!got) check("grant_timeout", 32'(req_ready), id ? 32'd2 : 32'd1);
    sb.push_back('{esum, eco, id});
    exp_rr = ~id;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    if (chk_lat) begin
      for (k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (res_valid) break;
      end
      check("latency", k, 32'd9);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_sum"},   res_sum,        32'd0);
    check({tag, "_res_co"},    32'(res_co),    32'd0);
    check({tag, "_res_id"},    32'(res_id),    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  logic [31:0] c_a[4], c_b[4], c_s[4];
  logic        c_ci[4], c_co[4];
  bit          got;

  initial begin
    c_a  = '{32'h0000_0010, 32'h0F0F_0F0F, 32'h8000_0000, 32'hDEAD_BEEF};
    c_b  = '{32'h0000_0020, 32'h00F0_00F1, 32'h8000_0000, 32'h1111_1111};
    c_ci = '{1'b0, 1'b1, 1'b1, 1'b0};
    c_s  = '{32'h0000_0030, 32'h0FFF_1001, 32'h0000_0001, 32'hEFBE_D000};
    c_co = '{1'b0, 1'b0, 1'b1, 1'b0};

    req_valid = '0; req_ci = '0; res_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    exp_rr = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      req_valid = 2'($urandom);
      req_ci    = 2'($urandom);
      res_ready = 1'($urandom);
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      @(negedge clk);
      check_zero_outputs("reset");
    end
    @(posedge clk);
    #1;
    req_valid = '0; req_ci = '0; res_ready = 1'b1;
    rst_n = 1'b1;

    // Single adds, carry ripple and wrap
    issue(1'b0, 32'h0000_1000, 32'h0000_0004, 1'b0, 32'h0000_1004, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    wait_idle();
    issue(1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    wait_idle();

    // Contention: both held valid, grants must alternate 0,1,0,1
    @(posedge clk);
    #1;
    load(1'b0, c_a[0], c_b[0], c_ci[0]);
    load(1'b1, c_a[1], c_b[1], c_ci[1]);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) got = 1'b1;
      end
      check("rr_grant", 32'(req_ready), exp_rr ? 32'd2 : 32'd1);
      sb.push_back('{c_s[g], c_co[g], exp_rr});
      @(posedge clk);
      #1;
      if (g + 2 < 4) load(exp_rr, c_a[g+2], c_b[g+2], c_ci[g+2]);
      if (g == 3) req_valid = 2'b00;
      exp_rr = ~exp_rr;
    end
    wait_idle();

    // Backpressure: result must hold and no new accept while DONE
    res_ready = 1'b0;
    issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_busy",      32'(busy),      32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_res_sum",   res_sum,        32'h2345_678A);
      check("bp_res_co",    32'(res_co),    32'd0);
      check("bp_res_id",    32'(res_id),    32'd0);
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_idle",  32'(busy),      32'd0);
    check("bp_release_valid", 32'(res_valid), 32'd0);

    // Abort mid-run at nibble step 4, then recover
    issue(1'b1, 32'h0000_1234, 32'h0000_1111, 1'b0, 32'h0000_2345, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    void'(sb.pop_back());
    exp_rr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_hold_valid", 32'(res_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_result", 32'(res_valid), 32'd0);
    end
    issue(1'b0, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 32'h0002_0000, 1'b0, 1'b1);
    wait_idle();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
